// File: rtl/taxi_axil_regfile_if.sv
// AXI4-Lite interface bundle with separate write and read modports for master and slave.
interface taxi_axil_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int STRB_W   = DATA_W / 8,
  parameter int AWUSER_W = 1,
  parameter int WUSER_W  = 1,
  parameter int BUSER_W  = 1,
  parameter int ARUSER_W = 1,
  parameter int RUSER_W  = 1
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic [AWUSER_W-1:0] awuser;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [STRB_W-1:0]   wstrb;
  logic [WUSER_W-1:0]  wuser;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic [BUSER_W-1:0]  buser;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic [ARUSER_W-1:0] aruser;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic [RUSER_W-1:0]  ruser;
  logic                rvalid;
  logic                rready;

  modport wr_mst (
    output awaddr, awprot, awuser, awvalid, input awready,
    output wdata, wstrb, wuser, wvalid, input wready,
    input bresp, buser, bvalid, output bready
  );

  modport wr_slv (
    input awaddr, awprot, awuser, awvalid, output awready,
    input wdata, wstrb, wuser, wvalid, output wready,
    output bresp, buser, bvalid, input bready
  );

  modport rd_mst (
    output araddr, arprot, aruser, arvalid, input arready,
    input rdata, rresp, ruser, rvalid, output rready
  );

  modport rd_slv (
    input araddr, arprot, aruser, arvalid, output arready,
    output rdata, rresp, ruser, rvalid, input rready
  );
endinterface

// File: rtl/taxi_axil_regfile.sv
// AXI4-Lite register bank: REG_CNT byte-strobed 32-bit registers, read-only status
// slots, per-register write pulses, one-cycle write and read response latency.
module taxi_axil_regfile #(
  parameter int                    REG_CNT = 16,
  parameter logic [REG_CNT-1:0]    RO_MASK = '0,
  parameter logic [REG_CNT*32-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  taxi_axil_if.wr_slv             s_axil_wr,
  taxi_axil_if.rd_slv             s_axil_rd,
  output logic [REG_CNT*32-1:0]   reg_out,
  output logic [REG_CNT-1:0]      reg_wr,
  input  logic [REG_CNT*32-1:0]   status_in
);

  localparam int DATA_W   = $bits(s_axil_wr.wdata);
  localparam int RDATA_W  = $bits(s_axil_rd.rdata);
  localparam int ADDR_W   = $bits(s_axil_wr.awaddr);
  localparam int STRB_W   = $bits(s_axil_wr.wstrb);
  localparam int IDX_W    = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;
  localparam logic [IDX_W:0] CNT_L = REG_CNT[IDX_W:0];
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  if (DATA_W != 32 || RDATA_W != 32) begin : g_bad_data_w
    $error("taxi_axil_regfile: interface DATA_W must be 32");
  end
  if (ADDR_W < IDX_W + 2) begin : g_bad_addr_w
    $error("taxi_axil_regfile: interface ADDR_W too narrow for REG_CNT");
  end

  logic [31:0]        regs_q [REG_CNT];
  logic [31:0]        regs_d [REG_CNT];
  logic [REG_CNT-1:0] reg_wr_q, reg_wr_d;
  logic               bvalid_q, bvalid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic               rvalid_q, rvalid_d;
  logic [1:0]         rresp_q, rresp_d;
  logic [31:0]        rdata_q, rdata_d;

  logic             wr_acc, ar_acc, wr_in, rd_in;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  // Acceptance ignores rst; the flops are held in reset anyway, only the readies gate on it
  assign wr_acc = s_axil_wr.awvalid && s_axil_wr.wvalid && (!bvalid_q || s_axil_wr.bready);
  assign ar_acc = s_axil_rd.arvalid && (!rvalid_q || s_axil_rd.rready);

  assign s_axil_wr.awready = !rst && s_axil_wr.awvalid && s_axil_wr.wvalid &&
                             (!bvalid_q || s_axil_wr.bready);
  assign s_axil_wr.wready  = s_axil_wr.awready;
  assign s_axil_rd.arready = !rst && (!rvalid_q || s_axil_rd.rready);

  assign wr_idx = s_axil_wr.awaddr[IDX_W+1:2];
  assign rd_idx = s_axil_rd.araddr[IDX_W+1:2];
  assign wr_in  = {1'b0, wr_idx} < CNT_L;
  assign rd_in  = {1'b0, rd_idx} < CNT_L;

  always_comb begin
    regs_d   = regs_q;
    reg_wr_d = '0;
    bvalid_d = bvalid_q && !s_axil_wr.bready;
    bresp_d  = bresp_q;
    if (wr_acc) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_in ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < REG_CNT; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          reg_wr_d[i] = 1'b1;
          if (!RO_MASK[i]) begin
            for (int k = 0; k < STRB_W; k++) begin
              if (s_axil_wr.wstrb[k]) regs_d[i][8*k +: 8] = s_axil_wr.wdata[8*k +: 8];
            end
          end
        end
      end
    end
  end

  // Read data comes from the pre-write register value, so same-cycle R/W returns old data
  always_comb begin
    rvalid_d = rvalid_q && !s_axil_rd.rready;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_acc) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_in ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = '0;
      for (int i = 0; i < REG_CNT; i++) begin
        if (rd_idx == IDX_W'(i)) rdata_d = RO_MASK[i] ? status_in[32*i +: 32] : regs_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) regs_q[i] <= RST_VAL[32*i +: 32];
      reg_wr_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      regs_q   <= regs_d;
      reg_wr_q <= reg_wr_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    for (int i = 0; i < REG_CNT; i++) reg_out[32*i +: 32] = RO_MASK[i] ? 32'h0 : regs_q[i];
  end

  assign reg_wr           = reg_wr_q;
  assign s_axil_wr.bvalid = bvalid_q;
  assign s_axil_wr.bresp  = bresp_q;
  assign s_axil_wr.buser  = '0;
  assign s_axil_rd.rvalid = rvalid_q;
  assign s_axil_rd.rresp  = rresp_q;
  assign s_axil_rd.rdata  = rdata_q;
  assign s_axil_rd.ruser  = '0;

  logic unused_sigs;
  assign unused_sigs = ^{s_axil_wr.awprot, s_axil_wr.awuser, s_axil_wr.wuser,
                         s_axil_rd.arprot, s_axil_rd.aruser,
                         s_axil_wr.awaddr, s_axil_rd.araddr};

endmodule

// File: tb/tb_taxi_axil_regfile.sv
// Bench for taxi_axil_regfile: directed table, hand-written handshake/reset sequences,
// and random traffic against a register-array model.
module tb_taxi_axil_regfile;
  localparam int               REG_CNT = 5;
  localparam logic [4:0]       RO_MASK = 5'b00100;
  localparam logic [159:0]     RST_VAL = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h11111111};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  taxi_axil_if #(.DATA_W(32), .ADDR_W(16)) axil ();

  logic [159:0] reg_out;
  logic [159:0] status_in;
  logic [4:0]   reg_wr;

  taxi_axil_regfile #(.REG_CNT(REG_CNT), .RO_MASK(RO_MASK), .RST_VAL(RST_VAL)) dut (
    .clk(clk),
    .rst(rst),
    .s_axil_wr(axil),
    .s_axil_rd(axil),
    .reg_out(reg_out),
    .reg_wr(reg_wr),
    .status_in(status_in)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] model [REG_CNT];

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [4:0]  regwr;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input logic [15:0] addr);
    n_vec++;
    n_miss++;
    $display("FAIL %s: no handshake within budget, addr %h", name, addr);
  endtask

  // Called and returns aligned to a falling edge.
  task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int hold, output logic [1:0] resp, output logic [4:0] seen);
    bit acc;
    acc = 1'b0;
    axil.awaddr  = addr;
    axil.wdata   = data;
    axil.wstrb   = strb;
    axil.awvalid = 1'b1;
    axil.wvalid  = 1'b1;
    axil.bready  = (hold == 0);
    for (int c = 0; c < 20 && !acc; c++) begin
      #1;
      acc = axil.awready && axil.wready;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    if (!acc) timeout("write_accept", addr);
    @(negedge clk);
    axil.awvalid = 1'b0;
    axil.wvalid  = 1'b0;
    resp = axil.bresp;
    seen = reg_wr;
    chk("bvalid_set", axil.bvalid, 1);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk("bvalid_hold", axil.bvalid, 1);
      chk("bresp_hold", axil.bresp, resp);
      chk("reg_wr_single", reg_wr, 0);
    end
    axil.bready = 1'b1;
    @(negedge clk);
    chk("bvalid_clr", axil.bvalid, 0);
    chk("reg_wr_clr", reg_wr, 0);
    axil.bready = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp);
    bit acc;
    acc = 1'b0;
    axil.araddr  = addr;
    axil.arvalid = 1'b1;
    axil.rready  = (hold == 0);
    for (int c = 0; c < 20 && !acc; c++) begin
      #1;
      acc = axil.arready;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    if (!acc) timeout("read_accept", addr);
    @(negedge clk);
    axil.arvalid = 1'b0;
    data = axil.rdata;
    resp = axil.rresp;
    chk("rvalid_set", axil.rvalid, 1);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk("rvalid_hold", axil.rvalid, 1);
      chk("rdata_hold", axil.rdata, data);
      chk("rresp_hold", axil.rresp, resp);
    end
    axil.rready = 1'b1;
    @(negedge clk);
    chk("rvalid_clr", axil.rvalid, 0);
    axil.rready = 1'b0;
  endtask

  task automatic chk_reg_out(input string name);
    for (int i = 0; i < REG_CNT; i++)
      chk(name, reg_out[32*i +: 32], RO_MASK[i] ? 32'h0 : model[i]);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [4:0]  seen;
    logic [31:0] rd;

    tbl[0]  = '{0, 16'h000C, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 5'b00000};
    tbl[1]  = '{0, 16'h0000, 32'h0,        4'h0, 2'b00, 32'h11111111, 5'b00000};
    tbl[2]  = '{1, 16'h0004, 32'h12345678, 4'hF, 2'b00, 32'h0,        5'b00010};
    tbl[3]  = '{1, 16'h0004, 32'h0000AB00, 4'h2, 2'b00, 32'h0,        5'b00010};
    tbl[4]  = '{0, 16'h0004, 32'h0,        4'h0, 2'b00, 32'h1234AB78, 5'b00000};
    tbl[5]  = '{1, 16'h0014, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0,        5'b00000};
    tbl[6]  = '{0, 16'h0014, 32'h0,        4'h0, 2'b10, 32'h0,        5'b00000};
    tbl[7]  = '{0, 16'h001C, 32'h0,        4'h0, 2'b10, 32'h0,        5'b00000};
    tbl[8]  = '{1, 16'h0008, 32'h00000001, 4'hF, 2'b00, 32'h0,        5'b00100};
    tbl[9]  = '{0, 16'h0008, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D, 5'b00000};
    tbl[10] = '{1, 16'h0010, 32'hA5A5A5A5, 4'h0, 2'b00, 32'h0,        5'b10000};
    tbl[11] = '{0, 16'h0010, 32'h0,        4'h0, 2'b00, 32'h0,        5'b00000};
    tbl[12] = '{1, 16'h0043, 32'hCAFE0000, 4'hC, 2'b00, 32'h0,        5'b00001};
    tbl[13] = '{0, 16'h0021, 32'h0,        4'h0, 2'b00, 32'hCAFE1111, 5'b00000};

    axil.awaddr = '0; axil.awprot = '0; axil.awuser = '0; axil.awvalid = 1'b1;
    axil.wdata = '0; axil.wstrb = '0; axil.wuser = '0; axil.wvalid = 1'b1; axil.bready = 1'b0;
    axil.araddr = '0; axil.arprot = '0; axil.aruser = '0; axil.arvalid = 1'b1; axil.rready = 1'b0;
    status_in = '0;
    status_in[64 +: 32] = 32'hCAFEF00D;
    for (int i = 0; i < REG_CNT; i++) model[i] = RST_VAL[32*i +: 32];

    // Reset state, readies forced low while rst is high
    #12;
    chk("rst_awready", axil.awready, 0);
    chk("rst_wready", axil.wready, 0);
    chk("rst_arready", axil.arready, 0);
    chk("rst_bvalid", axil.bvalid, 0);
    chk("rst_rvalid", axil.rvalid, 0);
    chk("rst_bresp", axil.bresp, 0);
    chk("rst_rresp", axil.rresp, 0);
    chk("rst_rdata", axil.rdata, 0);
    chk("rst_reg_wr", reg_wr, 0);
    chk_reg_out("rst_reg_out");
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 14; v++) begin
      if (tbl[v].is_wr) begin
        do_write(tbl[v].addr, tbl[v].data, tbl[v].strb, 0, resp, seen);
        chk($sformatf("tbl%0d_bresp", v), resp, tbl[v].resp);
        chk($sformatf("tbl%0d_reg_wr", v), seen, tbl[v].regwr);
      end else begin
        do_read(tbl[v].addr, 0, rd, resp);
        chk($sformatf("tbl%0d_rresp", v), resp, tbl[v].resp);
        chk($sformatf("tbl%0d_rdata", v), rd, tbl[v].rdata);
      end
    end

    // Same-cycle read and write of register 1: read sees the old value
    axil.awaddr = 16'h0004; axil.wdata = 32'h00000009; axil.wstrb = 4'hF;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.bready = 1'b1;
    axil.araddr = 16'h0004; axil.arvalid = 1'b1; axil.rready = 1'b1;
    #1;
    chk("rw_awready", axil.awready, 1);
    chk("rw_arready", axil.arready, 1);
    @(negedge clk);
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
    chk("rw_rvalid", axil.rvalid, 1);
    chk("rw_rdata_old", axil.rdata, 32'h1234AB78);
    chk("rw_bvalid", axil.bvalid, 1);
    chk("rw_reg_out_new", reg_out[63:32], 32'h00000009);
    @(negedge clk);
    chk("rw_bvalid_clr", axil.bvalid, 0);
    chk("rw_rvalid_clr", axil.rvalid, 0);
    axil.bready = 1'b0; axil.rready = 1'b0;

    // Backpressure: one transaction per channel while responses are held
    axil.awaddr = 16'h0000; axil.wdata = 32'h00000055; axil.wstrb = 4'h1;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    axil.araddr = 16'h000C; axil.arvalid = 1'b1;
    #1;
    chk("bp_awready0", axil.awready, 1);
    chk("bp_arready0", axil.arready, 1);
    @(negedge clk);
    chk("bp_bvalid", axil.bvalid, 1);
    chk("bp_rvalid", axil.rvalid, 1);
    chk("bp_rdata", axil.rdata, 32'hDEADBEEF);
    chk("bp_reg_wr", reg_wr, 5'b00001);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_awready", axil.awready, 0);
      chk("bp_wready", axil.wready, 0);
      chk("bp_arready", axil.arready, 0);
      chk("bp_bvalid_hold", axil.bvalid, 1);
      chk("bp_bresp_hold", axil.bresp, 2'b00);
      chk("bp_rvalid_hold", axil.rvalid, 1);
      chk("bp_rdata_hold", axil.rdata, 32'hDEADBEEF);
      chk("bp_reg_wr_once", reg_wr, 0);
    end
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
    axil.bready = 1'b1; axil.rready = 1'b1;
    @(negedge clk);
    chk("bp_bvalid_clr", axil.bvalid, 0);
    chk("bp_rvalid_clr", axil.rvalid, 0);
    axil.bready = 1'b0; axil.rready = 1'b0;
    do_read(16'h0000, 0, rd, resp);
    chk("bp_reg0", rd, 32'hCAFE1155);

    // Reset with responses pending
    axil.awaddr = 16'h0004; axil.wdata = 32'h00000077; axil.wstrb = 4'hF;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    axil.araddr = 16'h0000; axil.arvalid = 1'b1;
    @(negedge clk);
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
    chk("mr_bvalid_pre", axil.bvalid, 1);
    chk("mr_rvalid_pre", axil.rvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_bvalid_async", axil.bvalid, 0);
    chk("mr_rvalid_async", axil.rvalid, 0);
    chk("mr_reg_wr_async", reg_wr, 0);
    axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.arvalid = 1'b1;
    #1;
    chk("mr_awready", axil.awready, 0);
    chk("mr_arready", axil.arready, 0);
    @(negedge clk);
    @(negedge clk);
    axil.wvalid = 1'b0; axil.arvalid = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("mr_aw_only_awready", axil.awready, 0);
      chk("mr_aw_only_bvalid", axil.bvalid, 0);
      chk("mr_aw_only_rvalid", axil.rvalid, 0);
      chk("mr_aw_only_reg_wr", reg_wr, 0);
    end
    axil.awvalid = 1'b0;
    for (int i = 0; i < REG_CNT; i++) model[i] = RST_VAL[32*i +: 32];
    chk_reg_out("mr_reg_out");
    do_read(16'h0000, 1, rd, resp);
    chk("mr_reg0", rd, 32'h11111111);
    do_read(16'h0004, 0, rd, resp);
    chk("mr_reg1", rd, 32'h0);
    do_read(16'h000C, 2, rd, resp);
    chk("mr_reg3", rd, 32'hDEADBEEF);

    // Random traffic against the register-array model
    for (int it = 0; it < 150; it++) begin
      logic [15:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          idx;
      int          hold;
      addr = 16'($urandom_range(0, 255));
      idx  = (int'(addr) / 4) % 8;
      hold = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        do_write(addr, data, strb, hold, resp, seen);
        if (idx < REG_CNT && !RO_MASK[idx]) begin
          for (int k = 0; k < 4; k++)
            if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
        end
        chk("rnd_bresp", resp, (idx < REG_CNT) ? 2'b00 : 2'b10);
        chk("rnd_reg_wr", seen, (idx < REG_CNT) ? (5'b00001 << idx) : 5'b00000);
        chk_reg_out("rnd_reg_out");
      end else begin
        logic [31:0] stat;
        stat = $urandom;
        status_in = {$urandom, $urandom, stat, $urandom, $urandom};
        do_read(addr, hold, rd, resp);
        chk("rnd_rresp", resp, (idx < REG_CNT) ? 2'b00 : 2'b10);
        chk("rnd_rdata", rd, (idx >= REG_CNT) ? 32'h0 : (RO_MASK[idx] ? stat : model[idx]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
